// File: rtl/matpow_result_streamer.sv
// rtl/matpow_result_streamer.sv - captures a finished N x N result matrix and streams it row-major over valid/ready
module matpow_result_streamer #(
  parameter int N     = 2,
  parameter int W     = 8,
  parameter int CNT_W = 8,
  localparam int RW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Ready,
  input  logic [N*N*W-1:0]   mat_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic [RW-1:0]      out_row,
  output logic [RW-1:0]      out_col,
  output logic               out_last,
  output logic               busy,
  output logic               overrun,
  output logic [CNT_W-1:0]   frames_sent
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [RW-1:0]    col_q, col_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             ovr_q, ovr_d;
  logic             capture;
  logic             last_el;
  logic [W-1:0]     buf_q [N][N];

  assign last_el = (row_q == RW'(N - 1)) && (col_q == RW'(N - 1));

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    frames_d = frames_q;
    ovr_d    = ovr_q;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Ready) begin
          capture = 1'b1;
          state_d = S_SEND;
          row_d   = '0;
          col_d   = '0;
        end
      end
      default: begin
        if (out_ready) begin
          if (last_el) begin
            frames_d = frames_q + CNT_W'(1);
            row_d    = '0;
            col_d    = '0;
            // A Ready coinciding with the final transfer starts the next frame with no bubble.
            if (Ready) begin
              capture = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else if (col_q == RW'(N - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + RW'(1);
          end
        end
        if (Ready && !(out_ready && last_el)) begin
          ovr_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      frames_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      frames_q <= frames_d;
      ovr_q    <= ovr_d;
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset term.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          buf_q[r][c] <= mat_in[(r*N+c)*W +: W];
        end
      end
    end
  end

  assign out_valid   = (state_q == S_SEND);
  assign busy        = (state_q == S_SEND);
  assign out_data    = (state_q == S_SEND) ? buf_q[row_q][col_q] : '0;
  assign out_row     = row_q;
  assign out_col     = col_q;
  assign out_last    = (state_q == S_SEND) && last_el;
  assign overrun     = ovr_q;
  assign frames_sent = frames_q;

endmodule
